// File: rtl/vga_tile_renderer.sv
// VGA tile-playfield renderer: internal sync timing, bordered GRID_W x GRID_H tiles, double-buffered row store.
// Define VGA_BLINK_EN to blink the failure border from a 6-bit frame counter.
module vga_tile_renderer #(
   parameter int H_VIS     = 640,
   parameter int H_FP      = 16,
   parameter int H_SYNC    = 96,
   parameter int H_BP      = 48,
   parameter int V_VIS     = 480,
   parameter int V_FP      = 10,
   parameter int V_SYNC    = 2,
   parameter int V_BP      = 33,
   parameter int TILE_LOG2 = 5,
   parameter int GRID_W    = 18,
   parameter int GRID_H    = 13,
   parameter int CBITS     = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             seg_valid,
   output logic             seg_ready,
   input  logic [4:0]       seg_x,
   input  logic [3:0]       seg_y,
   input  logic [1:0]       seg_kind,
   input  logic [3:0]       seg_dirs,
   input  logic [1:0]       status,
   output logic             row_req,
   output logic [3:0]       row_req_y,
   output logic             frame_start,
   output logic [CBITS-1:0] r,
   output logic [CBITS-1:0] g,
   output logic [CBITS-1:0] b,
   output logic             hsync,
   output logic             vsync
);
   localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
   localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;
   localparam int XW    = $clog2(H_TOT);
   localparam int YW    = $clog2(V_TOT);
   localparam int T     = 1 << TILE_LOG2;
   localparam int M     = T / 8;
   localparam int IW    = (GRID_W > 1) ? $clog2(GRID_W) : 1;

   localparam logic [XW-1:0] X_LAST = XW'(H_TOT - 1);
   localparam logic [XW-1:0] X_VIS  = XW'(H_VIS);
   localparam logic [XW-1:0] X_HS0  = XW'(H_VIS + H_FP);
   localparam logic [XW-1:0] X_HS1  = XW'(H_VIS + H_FP + H_SYNC);
   localparam logic [XW-1:0] X_GB   = XW'(GRID_W + 1);
   localparam logic [YW-1:0] Y_LAST = YW'(V_TOT - 1);
   localparam logic [YW-1:0] Y_VIS  = YW'(V_VIS);
   localparam logic [YW-1:0] Y_VS0  = YW'(V_VIS + V_FP);
   localparam logic [YW-1:0] Y_VS1  = YW'(V_VIS + V_FP + V_SYNC);
   localparam logic [YW-1:0] Y_GB   = YW'(GRID_H + 1);
   localparam logic [YW-1:0] Y_GH   = YW'(GRID_H);
   localparam logic [TILE_LOG2-1:0] S_LO = TILE_LOG2'(M);
   localparam logic [TILE_LOG2-1:0] S_HI = TILE_LOG2'(T - M);
   localparam logic [CBITS-1:0] ON = '1;

   logic [XW-1:0]        px_q, px_d, tx;
   logic [YW-1:0]        py_q, py_d, ty, ty_next;
   logic [TILE_LOG2-1:0] sx, sy;
   logic                 sel_q;
   logic [5:0]           bank_q [2][GRID_W];
   logic [3:0]           row_req_y_q, row_req_y_d;
   logic                 row_req_q, frame_start_q, hsync_q, vsync_q;
   logic [CBITS-1:0]     r_q, g_q, b_q, r_d, g_d, b_d;
   logic                 swap, wr_en, in_box, on_border, cx, cy, arm, blank_border;
   logic [IW-1:0]        rd_idx, wr_idx;
   logic [5:0]           ent, old, merged;

   always_comb begin
      px_d = px_q + 1'b1;
      py_d = py_q;
      if (px_q == X_LAST) begin
         px_d = '0;
         py_d = (py_q == Y_LAST) ? '0 : py_q + 1'b1;
      end
   end

   assign tx      = px_q >> TILE_LOG2;
   assign ty      = py_q >> TILE_LOG2;
   assign sx      = px_q[TILE_LOG2-1:0];
   assign sy      = py_q[TILE_LOG2-1:0];
   assign ty_next = ty + YW'(2);

   // Swap on the last line of each tile row, plus the frame's final line to prime row 0.
   assign swap = (px_q == X_VIS) && (((py_q < Y_VIS) && (&sy)) || (py_q == Y_LAST));

   always_comb begin
      if (py_q == Y_LAST)     row_req_y_d = 4'd1;
      else if (ty_next > Y_GH) row_req_y_d = '0;
      else                     row_req_y_d = 4'(ty_next);
   end

   assign seg_ready = rst_n & ~swap;
   assign wr_en  = seg_valid && !swap && (seg_y == row_req_y_q) && (seg_x != 5'd0) && (seg_x <= 5'(GRID_W));
   assign wr_idx = IW'(seg_x - 5'd1);
   assign old    = bank_q[~sel_q][wr_idx];
   assign merged = {(seg_kind != 2'd0) ? seg_kind : old[5:4], old[3:0] | seg_dirs};

   assign rd_idx    = IW'(tx - XW'(1));
   assign ent       = bank_q[sel_q][rd_idx];
   assign in_box    = (tx <= X_GB) && (ty <= Y_GB);
   assign on_border = in_box && ((tx == '0) || (tx == X_GB) || (ty == '0) || (ty == Y_GB));
   assign cx        = (sx >= S_LO) && (sx < S_HI);
   assign cy        = (sy >= S_LO) && (sy < S_HI);
   assign arm = (cx && cy) || (ent[0] && cx && (sy < S_LO)) || (ent[1] && cx && (sy >= S_HI))
              || (ent[2] && cy && (sx < S_LO)) || (ent[3] && cy && (sx >= S_HI));

`ifdef VGA_BLINK_EN
   logic [5:0] fcnt_q;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)             fcnt_q <= '0;
      else if (frame_start_q) fcnt_q <= fcnt_q + 6'd1;
   end
   assign blank_border = (status == 2'b01) && fcnt_q[4];
`else
   assign blank_border = 1'b0;
`endif

   always_comb begin
      r_d = '0;
      g_d = '0;
      b_d = '0;
      if ((px_q < X_VIS) && (py_q < Y_VIS)) begin
         if (on_border) begin
            if (!blank_border) begin
               case (status)
                  2'b01:   r_d = ON;
                  2'b10:   g_d = ON;
                  default: begin r_d = ON; g_d = ON; b_d = ON; end
               endcase
            end
         end else if (in_box) begin
            case (ent[5:4])
               2'd1:    if (arm) g_d = ON;
               2'd2:    if (cx && cy) r_d = ON;
               2'd3:    b_d = ON;
               default: ;
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         px_q        <= '0;
         py_q        <= '0;
         sel_q       <= 1'b0;
         row_req_q   <= 1'b0;
         row_req_y_q <= '0;
         for (int unsigned i = 0; i < GRID_W; i++) begin
            bank_q[0][i] <= '0;
            bank_q[1][i] <= '0;
         end
      end else begin
         px_q      <= px_d;
         py_q      <= py_d;
         row_req_q <= swap;
         if (swap) begin
            sel_q       <= ~sel_q;
            row_req_y_q <= row_req_y_d;
            for (int unsigned i = 0; i < GRID_W; i++) bank_q[sel_q][i] <= '0;
         end else if (wr_en) begin
            bank_q[~sel_q][wr_idx] <= merged;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_q           <= '0;
         g_q           <= '0;
         b_q           <= '0;
         hsync_q       <= 1'b1;
         vsync_q       <= 1'b1;
         frame_start_q <= 1'b0;
      end else begin
         r_q           <= r_d;
         g_q           <= g_d;
         b_q           <= b_d;
         hsync_q       <= !((px_q >= X_HS0) && (px_q < X_HS1));
         vsync_q       <= !((py_q >= Y_VS0) && (py_q < Y_VS1));
         frame_start_q <= (px_q == '0) && (py_q == '0);
      end
   end

   assign r           = r_q;
   assign g           = g_q;
   assign b           = b_q;
   assign hsync       = hsync_q;
   assign vsync       = vsync_q;
   assign frame_start = frame_start_q;
   assign row_req     = row_req_q;
   assign row_req_y   = row_req_y_q;
endmodule

// File: tb/tb_vga_tile_renderer.sv
// Self-checking bench for vga_tile_renderer: reduced timing, random row streams, tile-map reference model.
module tb_vga_tile_renderer;
   localparam int HV = 112, HF = 4, HS = 8, HB = 4;
   localparam int VV = 96, VF = 2, VS = 3, VB = 3;
   localparam int TL = 4, GW = 4, GH = 3, CB = 2;
   localparam int HT = HV + HF + HS + HB;
   localparam int VT = VV + VF + VS + VB;
   localparam int FT = HT * VT;
   localparam int T = 1 << TL;
   localparam int M = T / 8;
   localparam int ON = (1 << CB) - 1;
   localparam int RED = ON << (2 * CB), GRN = ON << CB, BLU = ON, WHT = RED | GRN | BLU;

   logic clk = 1'b0;
   logic rst_n;
   logic seg_valid, seg_ready;
   logic [4:0] seg_x;
   logic [3:0] seg_y, seg_dirs, row_req_y;
   logic [1:0] seg_kind, status;
   logic row_req, frame_start, hsync, vsync;
   logic [CB-1:0] r, g, b;

   vga_tile_renderer #(
      .H_VIS(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
      .V_VIS(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
      .TILE_LOG2(TL), .GRID_W(GW), .GRID_H(GH), .CBITS(CB)
   ) dut (
      .clk(clk), .rst_n(rst_n), .seg_valid(seg_valid), .seg_ready(seg_ready),
      .seg_x(seg_x), .seg_y(seg_y), .seg_kind(seg_kind), .seg_dirs(seg_dirs),
      .status(status), .row_req(row_req), .row_req_y(row_req_y),
      .frame_start(frame_start), .r(r), .g(g), .b(b), .hsync(hsync), .vsync(vsync)
   );

   always #5 clk = ~clk;

   typedef struct { int x; int y; int kind; int dirs; } ent_t;
   ent_t q[$];
   int fk [0:15][0:GW+1];
   int fd [0:15][0:GW+1];
   int checks = 0, errors = 0;
   int c, cur_y;
   bit exp_req;
   int st_tab [4] = '{1, 2, 0, 3};

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s c=%0d observed=%0h expected=%0h", tag, c, obs, exp);
      end
   endtask

   task automatic clear_model();
      for (int y = 0; y < 16; y++)
         for (int x = 0; x <= GW + 1; x++) begin fk[y][x] = 0; fd[y][x] = 0; end
      cur_y = 0;
      exp_req = 0;
      q.delete();
   endtask

   function automatic bit is_swap(input int x, input int y);
      return (x == HV) && (((y < VV) && ((y % T) == T - 1)) || (y == VT - 1));
   endfunction

   function automatic int target_row(input int y);
      if (y == VT - 1) return 1;
      return (y / T + 2 > GH) ? 0 : y / T + 2;
   endfunction

   function automatic bit band(input int v);
      return (v >= M) && (v < T - M);
   endfunction

   function automatic int exp_px(input int x, input int y, input int st);
      int tx, ty, sx, sy, k, d;
      if (x >= HV || y >= VV) return 0;
      tx = x / T; ty = y / T; sx = x % T; sy = y % T;
      if (tx > GW + 1 || ty > GH + 1) return 0;
      if (tx == 0 || tx == GW + 1 || ty == 0 || ty == GH + 1)
         return (st == 1) ? RED : (st == 2) ? GRN : WHT;
      k = fk[ty][tx]; d = fd[ty][tx];
      case (k)
         1: if ((band(sx) && band(sy)) || (d[0] && band(sx) && sy < M) || (d[1] && band(sx) && sy >= T - M)
                || (d[2] && band(sy) && sx < M) || (d[3] && band(sy) && sx >= T - M)) return GRN;
         2: if (band(sx) && band(sy)) return RED;
         3: return BLU;
         default: ;
      endcase
      return 0;
   endfunction

   task automatic check_reset_vals();
      chk("rst_rgb", {r, g, b}, 0);
      chk("rst_hsync", hsync, 1);
      chk("rst_vsync", vsync, 1);
      chk("rst_frame_start", frame_start, 0);
      chk("rst_row_req", row_req, 0);
      chk("rst_row_req_y", row_req_y, 0);
      chk("rst_seg_ready", seg_ready, 0);
   endtask

   task automatic step();
      int x0, y0, xn, yn, st_at, n;
      bit acc;
      ent_t e;
      x0 = c % HT; y0 = (c / HT) % VT;
      acc = seg_valid && !is_swap(x0, y0);
      st_at = int'(status);
      @(posedge clk);
      if (acc) begin
         e = q.pop_front();
         if (e.y == cur_y && e.x >= 1 && e.x <= GW) begin
            fd[cur_y][e.x] = fd[cur_y][e.x] | e.dirs;
            if (e.kind != 0) fk[cur_y][e.x] = e.kind;
         end
      end
      exp_req = is_swap(x0, y0);
      if (exp_req) begin
         cur_y = target_row(y0);
         for (int i = 0; i <= GW + 1; i++) begin fk[cur_y][i] = 0; fd[cur_y][i] = 0; end
      end
      c++;
      @(negedge clk);
      chk("rgb", {r, g, b}, exp_px(x0, y0, st_at));
      chk("hsync", hsync, !(x0 >= HV + HF && x0 < HV + HF + HS));
      chk("vsync", vsync, !(y0 >= VV + VF && y0 < VV + VF + VS));
      chk("frame_start", frame_start, (x0 == 0 && y0 == 0));
      chk("row_req", row_req, exp_req);
      chk("row_req_y", row_req_y, cur_y);
      xn = c % HT; yn = (c / HT) % VT;
      chk("seg_ready", seg_ready, !is_swap(xn, yn));
      if (exp_req) begin
         if (cur_y == 3) begin
            e = '{x: 2, y: 3, kind: 1, dirs: 5};
            q.push_back(e);
         end
         n = $urandom_range(9, 4);
         for (int i = 0; i < n; i++) begin
            e.x = $urandom_range(GW + 1, 0);
            e.y = ($urandom_range(3, 0) == 0) ? (cur_y + 1) % 16 : cur_y;
            e.kind = $urandom_range(3, 0);
            e.dirs = $urandom_range(15, 0);
            q.push_back(e);
         end
      end
      // Hold an entry for the upcoming row across the swap into row 3.
      if (xn == HV - 3 && (yn % T) == T - 1 && yn / T == 1) begin
         e = '{x: 1, y: target_row(yn), kind: 2, dirs: 8};
         repeat (6) q.push_back(e);
      end
      if (c % FT == 0) status = 2'(st_tab[(c / FT) % 4]);
      if (q.size() > 0) begin
         seg_valid = 1'b1;
         seg_x = 5'(q[0].x); seg_y = 4'(q[0].y);
         seg_kind = 2'(q[0].kind); seg_dirs = 4'(q[0].dirs);
      end else begin
         seg_valid = 1'b0;
         seg_x = 5'($urandom); seg_y = 4'($urandom);
         seg_kind = 2'($urandom); seg_dirs = 4'($urandom);
      end
   endtask

   initial begin
      rst_n = 1'b0; seg_valid = 1'b0; seg_x = '0; seg_y = '0; seg_kind = '0; seg_dirs = '0;
      status = 2'(st_tab[0]);
      c = 0;
      clear_model();
      repeat (3) @(negedge clk);
      check_reset_vals();
      rst_n = 1'b1;
      repeat (3 * FT + 40 * HT + 60) step();

      rst_n = 1'b0;
      #1;
      check_reset_vals();
      clear_model();
      seg_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      c = 0;
      status = 2'(st_tab[0]);
      rst_n = 1'b1;
      repeat (FT + 200) step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/vga_tile_renderer.md
Name: vga_tile_renderer

Overview:
Parametrised successor of the snake-game VGA renderer. Generates VGA timing internally and draws a GRID_W x GRID_H tile playfield with a one-tile border. Tiles are 2^TILE_LOG2 pixels square, and channel depth is CBITS. Tile contents arrive over a valid/ready segment stream into a double-buffered row store: tile row n is displayed while row n+1 fills. Four tile kinds are supported: empty, snake, apple and obstacle.

Parameters:
H_VIS, 640, visible pixels per line
H_FP, 16, horizontal front porch
H_SYNC, 96, hsync width
H_BP, 48, horizontal back porch
V_VIS, 480, visible lines
V_FP, 10, vertical front porch
V_SYNC, 2, vsync width
V_BP, 33, vertical back porch
TILE_LOG2, 5, log2 of tile edge in pixels (range 3..6)
GRID_W, 18, playfield tiles per row; needs (GRID_W+2)<<TILE_LOG2 <= H_VIS
GRID_H, 13, playfield tile rows; needs (GRID_H+2)<<TILE_LOG2 <= V_VIS
CBITS, 2, bits per colour channel

Ports:
clk  in  1  clock; one pixel per cycle
rst_n  in  1  asynchronous active-low reset
seg_valid  in  1  segment entry valid
seg_ready  out  1  segment entry accepted when valid and ready are both high
seg_x  in  5  playfield column, 1..GRID_W
seg_y  in  4  playfield row, 1..GRID_H
seg_kind  in  2  tile kind: 0 empty, 1 snake, 2 apple, 3 obstacle
seg_dirs  in  4  snake connection arms: bit0 up, bit1 down, bit2 left, bit3 right
status  in  2  00 running, 01 failure, 10 success, 11 treated as running
row_req  out  1  one-cycle pulse: fill bank cleared, producer may stream row_req_y
row_req_y  out  4  tile row now being filled
frame_start  out  1  one-cycle pulse at px=0, py=0
r  out  CBITS  red
g  out  CBITS  green
b  out  CBITS  blue
hsync  out  1  active low
vsync  out  1  active low

Behaviour:
- Reset values (asynchronous): px=py=0, both banks cleared, seg_ready=0, row_req=0, row_req_y=0, frame_start=0, r=g=b=0, hsync=vsync=1. The first cycle after reset release is px=0, py=0.
- Timing counters:
  - px counts 0..H_VIS+H_FP+H_SYNC+H_BP-1 and wraps; py increments on px wrap and wraps after V total.
  - hsync is low for px in [H_VIS+H_FP, H_VIS+H_FP+H_SYNC); vsync uses the same rule on py.
- Output registration: r, g, b, hsync and vsync are all registered with a 1-cycle latency from the (px,py) they describe. frame_start is registered and aligned with the pixel at (0,0).
- Tile coordinates: tx = px>>TILE_LOG2, ty = py>>TILE_LOG2, sub = low TILE_LOG2 bits. Margin M = 2^TILE_LOG2/8; the centre band is sub in [M, 2^TILE_LOG2-M).
- Banks: two banks, each GRID_W entries of {kind[1:0], dirs[3:0]}. The display bank supplies tile row ty; the fill bank collects row ty+1.
- Bank swap:
  - Occurs at px=H_VIS on the last pixel line of a tile row, and also at px=H_VIS, py=V_total-1 to prime row 0.
  - The swap cycle flips the banks, clears the new fill bank, pulses row_req and sets row_req_y to the next row. The row after the last drawn row wraps to 0.
  - seg_ready is 0 during the swap cycle and during reset, and 1 otherwise.
- Segment accept:
  - An entry with seg_y==row_req_y and 1<=seg_x<=GRID_W writes the fill bank: dirs are ORed in; a nonzero kind overwrites and kind 0 keeps the old kind.
  - Entries for any other row or column are accepted and dropped.
  - Entries that miss the swap are lost; the producer restarts on row_req.
- Pixel colour:
  - Outside the visible area: black.
  - Border (tx==0, tx==GRID_W+1, ty==0, ty==GRID_H+1): white when running, green on success, red on failure.
  - Beyond the border: black.
  - Snake: green in the centre square. An arm fills the centre band from the centre square to the tile edge when its dir bit is set. Corners and other margin areas are black.
  - Apple: red in the centre square.
  - Obstacle: blue over the whole tile.
  - Empty: black.
  - White = all ones. Green, red and blue are all ones on their own channel and zero elsewhere.
- Reset mid-frame: counters, banks and outputs return to reset values immediately. No partial row is kept.

Optional Feature:
Macro VGA_BLINK_EN.
- Defined: a 6-bit frame counter increments on frame_start. While status==01, the border is black whenever counter bit 4 is 1, so it blinks about every 16 frames.
- Not defined: no counter is built, and the failure border is steady red.

Test Plan:
- Reset, then run 800x525 cycles at default parameters -> hsync low for exactly 96 cycles per line starting at px=656; vsync low on lines 490-491; one frame_start per frame.
- status=01 with empty banks -> pixels at (0..31, 0..31) red, interior black; status=10 -> border green.
- On row_req with row_req_y=3, stream {x=5,y=3,kind=1,dirs=0101} -> tile (5,3) is green in the centre square plus the up arm and the left arm; pixel (5*32+1, 3*32+1) is black.
- Stream {x=7,y=4,kind=2} while row_req_y=3 -> accepted with seg_ready=1 and not drawn; stream {x=0,y=3} -> dropped.
- Hold seg_valid across a swap -> seg_ready=0 for exactly one cycle; the entry after the swap lands in the new row only if seg_y matches.
- Assert rst_n low mid-line at px=300 -> r=g=b=0 and hsync=vsync=1 immediately; after release, banks are empty and px restarts at 0.
